fifo_burst_ctrl: RTL and testbench
==================================

# fifo_burst_ctrl

Read-side controller for the synchronous sample FIFO. It drains the FIFO into framed packets on a valid/ready stream toward the host link, and it is the FIFO's only reader. Each packet is one header word followed by BURST_LEN data words. A partial packet is flushed when data has been waiting in the FIFO for TIMEOUT_CYCLES.

## Interface
- DATA_WIDTH, 32: FIFO word and stream width; must be ≥ 32.
- ADDR_WIDTH, 10: FIFO address width; fifo_count is ADDR_WIDTH+1 bits.
- BURST_LEN, 16: data words per full packet; legal range 1..min(2^ADDR_WIDTH, 65535).
- TIMEOUT_CYCLES, 4096: idle cycles with a non-empty FIFO before a partial flush; must be ≥ 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  allows new packets; sampled only in IDLE.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_rd_data  in  DATA_WIDTH  FIFO registered read data, valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_count  in  ADDR_WIDTH+1  FIFO occupancy.
- m_data  out  DATA_WIDTH  stream data, registered.
- m_valid  out  1  stream valid.
- m_last  out  1  marks the final data word of a packet.
- m_ready  in  1  sink accept.
- busy  out  1  high whenever the state is not IDLE.
- pkt_seq  out  8  sequence number of the next or current packet.

## Operation
- States are IDLE, HDR, RD, LD and SEND; state is encoded one-hot or binary.
- The outputs m_valid, m_last, fifo_rd_en and busy decode from registered state only. There is no combinational path from m_ready to any output.
- **IDLE:**
  - Timer increments each cycle while enable=1 and fifo_empty=0.
  - Timer clears when enable=0, when fifo_empty=1, or on leaving IDLE.
  - If enable=1 and fifo_count ≥ BURST_LEN: load len=BURST_LEN and go to HDR.
  - Else if enable=1, fifo_empty=0 and timer = TIMEOUT_CYCLES-1: load len=fifo_count and go to HDR. fifo_count is necessarily < BURST_LEN here.
  - When both conditions hold, the full-burst condition wins.
  - m_data is loaded with the header {0…, 8'hA5, pkt_seq[7:0], len[15:0]}.
- **HDR:**
  - m_valid=1, m_last=0.
  - On m_ready: remaining=len, go to RD.
- **RD:**
  - fifo_rd_en=1 for exactly one cycle, then go to LD.
  - No emptiness check is needed: len ≤ fifo_count at the decision point, and this block is the sole reader.
- **LD:**
  - m_data ← fifo_rd_data, go to SEND.
- **SEND:**
  - m_valid=1, m_last=(remaining==1).
  - m_data is held stable while m_ready=0.
  - On m_ready with remaining>1: remaining decrements, go to RD.
  - On m_ready with remaining==1: pkt_seq increments (mod 256), go to IDLE.
- Deasserting enable mid-packet has no effect. The packet always completes; enable only gates new packets.
- Concurrent FIFO writes only raise fifo_count and do not disturb an active packet.
- Width rules:
  - remaining is 16 bits.
  - pkt_seq wraps 0xFF→0x00.
  - Header bits above 31 are zero.

## Timing
- Reset values: m_valid=0, m_last=0, m_data=0, fifo_rd_en=0, busy=0, pkt_seq=0, timer=0, state=IDLE.
- Reset mid-packet aborts the packet: all outputs return to their reset values on the cycle after rst is sampled high. The partially read data is lost, and the FIFO is reset alongside this block.
- Trigger latency: condition true at edge k → HDR (m_valid=1 with the header) visible in cycle k+1.
- Per-word cost: RD→LD→SEND with m_ready=1 takes 3 cycles, so a full packet takes 1 + 3·len cycles minimum.
- Flush timing: first non-empty cycle in IDLE at edge k with no further writes → HDR in cycle k+TIMEOUT_CYCLES.
- Read accounting: exactly len fifo_rd_en pulses per packet, one per data word. Each pulse is at least 2 cycles after the previous accepted transfer.
- Handshake: a transfer occurs when m_valid and m_ready are both high on a rising edge. m_valid never drops before a transfer.

## Test plan
- **Full burst:** rst, write 16 words 0x100..0x10F, enable=1, m_ready=1 → header 0x00A50010, then 0x100..0x10F in order. m_last only on 0x10F. pkt_seq=1 afterward. fifo_empty=1.
- **Backpressure:** same setup with m_ready=0 for 10 cycles at data word 5 → m_data=0x105 and m_valid held stable. Exactly 16 fifo_rd_en pulses total. No duplicated or dropped words.
- **Timeout flush** (TIMEOUT_CYCLES=64): write 3 words 0xA,0xB,0xC → header 0x00A50003 appears 64 cycles after the first write is visible. m_last on 0xC, busy returns to 0.
- **Timer vs burst:** write 15 words, add the 16th at timer=40 (TIMEOUT_CYCLES=64) → header len=16 and no partial packet. Timer reads 0 on return to IDLE.
- **Reset mid-packet:** assert rst after data word 7 is accepted → next cycle m_valid=0, m_last=0, m_data=0, busy=0, pkt_seq=0, fifo_rd_en=0.
- **Enable and seq wrap:**
  - enable=0 with fifo_count=16 → no m_valid for 200 cycles.
  - enable dropped after the header → packet still completes.
  - 256 consecutive packets → header seq fields 0x00..0xFF, then 0x00.

Source files
------------

// File: rtl/fifo_burst_ctrl.sv
// Read-side controller that drains the sample FIFO into framed packets
// (one header word, then up to BURST_LEN data words) on a valid/ready stream.
module fifo_burst_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned BURST_LEN      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH:0]   fifo_count,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [7:0]            pkt_seq
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {IDLE, HDR, RD, LD, SEND} state_t;

  state_t                state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           remaining_q, remaining_d;
  logic [7:0]            pkt_seq_q, pkt_seq_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;

  logic burst_ready;
  logic timeout_hit;

  assign burst_ready = 32'(fifo_count) >= BURST_LEN;
  assign timeout_hit = !fifo_empty && (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    // NOTE: every signal gets its hold/idle value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    timer_d     = '0;
    len_d       = len_q;
    remaining_d = remaining_q;
    pkt_seq_d   = pkt_seq_q;
    m_data_d    = m_data_q;

    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) timer_d = timer_q + TIMER_W'(1);
        // A full burst takes priority over a timeout that fires in the same cycle.
        if (enable && burst_ready) begin
          len_d   = 16'(BURST_LEN);
          state_d = HDR;
        end else if (enable && timeout_hit) begin
          len_d   = 16'(fifo_count);
          state_d = HDR;
        end
        if (state_d == HDR) begin
          timer_d  = '0;
          m_data_d = DATA_WIDTH'({8'hA5, pkt_seq_q, len_d});
        end
      end
      HDR: begin
        if (m_ready) begin
          remaining_d = len_q;
          state_d     = RD;
        end
      end
      RD: state_d = LD;
      LD: begin
        m_data_d = fifo_rd_data;
        state_d  = SEND;
      end
      SEND: begin
        if (m_ready) begin
          if (remaining_q == 16'd1) begin
            pkt_seq_d = pkt_seq_q + 8'd1;
            state_d   = IDLE;
          end else begin
            remaining_d = remaining_q - 16'd1;
            state_d     = RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies decoded from the next state, so m_ready
    // never reaches a port combinationally.
    m_valid_d = (state_d == HDR) || (state_d == SEND);
    m_last_d  = (state_d == SEND) && (remaining_d == 16'd1);
    rd_en_d   = (state_d == RD);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      pkt_seq_q   <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      pkt_seq_q   <= pkt_seq_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign busy       = busy_q;
  assign pkt_seq    = pkt_seq_q;

endmodule

// File: tb/tb_fifo_burst_ctrl.sv
// Scoreboard bench for fifo_burst_ctrl: a queue-based FIFO feeds the DUT, a
// packet model predicts the stream, and a negedge monitor compares transfers.
module tb_fifo_burst_ctrl;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BL = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_rd_en, m_valid, m_last, busy;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic [DW-1:0] m_data;
  logic [AW:0]   fifo_count = '0;
  logic [7:0]    pkt_seq;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int xfer_cnt = 0;
  int data_xfer_cnt = 0;
  int hdr_cyc = 0;
  int last_cyc = 0;
  int rise_cyc = 0;
  int pkts = 0;
  bit rand_ready = 1'b0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          hdr;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_fifo[$];
  logic [DW-1:0] fq[$];
  logic [7:0]    ref_seq = 8'd0;

  fifo_burst_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .pkt_seq(pkt_seq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Synchronous FIFO with registered read data, reset together with the DUT.
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fifo_rd_data <= '0;
    end else begin
      if (fifo_rd_en) begin
        rd_cnt++;
        check("rd_underflow", (fq.size() > 0) ? 64'd1 : 64'd0, 64'd1);
        if (fq.size() > 0) fifo_rd_data <= fq.pop_front();
      end
      if (wr_en) fq.push_back(wr_data);
    end
    fifo_count <= (AW+1)'(fq.size());
    fifo_empty <= (fq.size() == 0);
  end

  // Packet model: whatever sits in the FIFO leaves as full bursts, then one partial.
  task automatic push_packet(input int len);
    exp_t e;
    e.data = {8'hA5, ref_seq, 16'(len)};
    e.last = 1'b0;
    e.hdr  = 1'b1;
    exp_q.push_back(e);
    ref_seq++;
    pkts++;
    for (int i = 0; i < len; i++) begin
      e.data = ref_fifo.pop_front();
      e.last = (i == len - 1);
      e.hdr  = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic predict();
    while (ref_fifo.size() >= BL) push_packet(BL);
    if (ref_fifo.size() > 0) push_packet(ref_fifo.size());
  endtask

  task automatic write_words(input logic [DW-1:0] base, input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      wr_data = rnd ? DW'($urandom) : base + DW'(i);
      wr_en   = 1'b1;
      ref_fifo.push_back(wr_data);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (exp_q.size() == 0 && !busy && fifo_empty) break;
      @(posedge clk); #1;
    end
    check("done_in_time", (i < limit) ? 64'd1 : 64'd0, 64'd1);
  endtask

  task automatic wait_data(input int target, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (data_xfer_cnt >= target) break;
      @(posedge clk); #1;
    end
    check("data_in_time", (i < limit) ? 64'd1 : 64'd0, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_fifo_rd_en"}, fifo_rd_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pkt_seq"}, pkt_seq, 0);
  endtask

  // Random backpressure when enabled.
  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) m_ready = ($urandom_range(0, 99) < 70);
  end

  // Monitor: inputs change just after posedge, so a negedge sample with
  // valid and ready both high is the transfer of the next rising edge.
  initial begin
    exp_t e;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        continue;
      end
      if (m_valid && !prev_valid) rise_cyc = cyc;
      if (prev_valid && !prev_ready) begin
        check("valid_held", m_valid, 1);
        check("data_held", m_data, prev_data);
      end
      if (exp_q.size() == 0) check("no_unexpected_valid", m_valid, 0);
      if (m_valid && m_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(e.hdr ? "header_word" : "data_word", m_data, e.data);
        check("m_last", m_last, e.last);
        xfer_cnt++;
        if (e.hdr) hdr_cyc = rise_cyc;
        else data_xfer_cnt++;
        if (e.last) last_cyc = rise_cyc;
      end
      prev_valid = m_valid;
      prev_ready = m_ready;
      prev_data  = m_data;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, h1, l1, r0, d0, x0, vcount, n, i;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Full burst with immediate trigger and back-to-back acceptance.
    m_ready = 1'b1;
    enable  = 1'b1;
    r0 = rd_cnt;
    write_words(32'h100, 16, 1'b0);
    c0 = cyc;
    predict();
    wait_done(400);
    check("full_hdr_latency", hdr_cyc, c0 + 1);
    check("full_last_timing", last_cyc, hdr_cyc + 48);
    check("full_pkt_seq", pkt_seq, ref_seq);
    check("full_fifo_empty", fifo_empty, 1);
    check("full_rd_pulses", rd_cnt - r0, 16);

    // Backpressure on data word 5.
    r0 = rd_cnt;
    d0 = data_xfer_cnt;
    write_words(32'h100, 16, 1'b0);
    predict();
    wait_data(d0 + 5, 400);
    m_ready = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
    end
    check("stall_m_valid", m_valid, 1);
    check("stall_m_data", m_data, 32'h105);
    check("stall_m_last", m_last, 0);
    m_ready = 1'b1;
    wait_done(400);
    check("stall_rd_pulses", rd_cnt - r0, 16);

    // Timeout flush of a 3-word partial packet.
    c0 = cyc;
    write_words(32'hA, 3, 1'b0);
    predict();
    wait_done(400);
    check("flush_hdr_latency", hdr_cyc, c0 + 1 + TO);
    check("flush_busy_idle", busy, 0);

    // 16th word arrives at timer=40: full burst wins, then the leftover two
    // words need a complete fresh timeout after returning to IDLE.
    c0 = cyc;
    write_words(32'h200, 15, 1'b0);
    while (cyc < c0 + 1 + 40) begin
      @(posedge clk); #1;
    end
    d0 = data_xfer_cnt;
    write_words(32'h20F, 1, 1'b0);
    predict();
    write_words(32'h210, 2, 1'b0);
    wait_data(d0 + 16, 400);
    h1 = hdr_cyc;
    l1 = last_cyc;
    predict();
    wait_done(400);
    check("burst_vs_timer_hdr", h1, c0 + 1 + 42);
    check("timer_cleared_flush", hdr_cyc, l1 + TO + 1);

    // Reset after data word 7 is accepted.
    d0 = data_xfer_cnt;
    write_words(32'h300, 16, 1'b0);
    predict();
    wait_data(d0 + 8, 400);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    rst = 1'b0;
    exp_q.delete();
    ref_fifo.delete();
    ref_seq = 8'd0;
    pkts = 0;
    @(posedge clk); #1;

    // enable low holds off packets; dropping it after the header does not stop one.
    enable = 1'b0;
    write_words(32'h400, 16, 1'b0);
    vcount = 0;
    repeat (200) begin
      @(negedge clk);
      if (m_valid) vcount++;
    end
    @(posedge clk); #1;
    check("enable_off_no_valid", vcount, 0);
    predict();
    enable = 1'b1;
    x0 = xfer_cnt;
    for (i = 0; i < 100 && xfer_cnt == x0; i++) begin
      @(posedge clk); #1;
    end
    check("enable_hdr_accepted", (xfer_cnt > x0) ? 64'd1 : 64'd0, 64'd1);
    enable = 1'b0;
    wait_done(400);
    check("enable_drop_seq", pkt_seq, ref_seq);

    // Random rounds with random backpressure until the sequence number wraps.
    rand_ready = 1'b1;
    while (pkts < 260) begin
      n = $urandom_range(1, 120);
      r0 = rd_cnt;
      write_words('0, n, 1'b1);
      predict();
      enable = 1'b1;
      wait_done(40 * n + 400);
      enable = 1'b0;
      check("rand_rd_pulses", rd_cnt - r0, n);
    end
    rand_ready = 1'b0;
    m_ready = 1'b1;
    check("wrap_pkt_seq", pkt_seq, ref_seq);
    check("wrap_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
